core_ex_pipe_ctrl: RTL and testbench
====================================

CORE_EX_PIPE_CTRL -- requirements
Module: core_ex_pipe_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath width.
REQ-002 SHALL have parameter PC_W, default 32, meaning PC width.
REQ-003 SHALL have parameter RFIDX_W, default 5, meaning register index width.
REQ-004 SHALL have parameter N_FU, default 3, meaning number of attached functional units (1..8).
REQ-005 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- valid_in / ready_in  in/out  1  upstream handshake.
- i_pc  in  PC_W  instruction PC.
- i_rd_wen  in  1  writes rd.
- i_rd_idx  in  RFIDX_W  destination index.
- i_fu_sel  in  N_FU  one-hot target FU.
- i_pred_taken  in  1  fetch-predicted taken.
- fu_req_valid / fu_req_ready  out/in  N_FU  per-FU issue handshake.
- fu_rsp_valid  in  N_FU  per-FU result strobe.
- fu_rsp_data  in  N_FU*XLEN  per-FU result, FU k at bits [k*XLEN +: XLEN].
- fu_bj_taken  in  1  resolved taken, valid with FU response.
- fu_bj_pc  in  PC_W  resolved target.
- i_kill  in  1  squash current op.
- valid_out / ready_out  out/in  1  writeback handshake.
- o_rd_wen, o_rd_idx, o_wb_data  out  1/RFIDX_W/XLEN  writeback payload.
- flush_req  out  1  mispredict redirect pulse.
- flush_pc  out  PC_W  redirect target.
- fwd_pending  out  1  rd in flight, result not yet available.
- fwd_valid  out  1  fwd_data usable.
- fwd_rd_idx  out  RFIDX_W  forwarded index.
- fwd_data  out  XLEN  forwarded value.

Function
REQ-006 SHALL implement states IDLE, ISSUE, WAIT, DONE, DRAIN.
REQ-007 SHALL assert ready_in only in IDLE, or in DONE in the cycle ready_out is high.
REQ-008 SHALL capture i_pc, i_rd_wen, i_rd_idx, i_fu_sel, i_pred_taken on valid_in&ready_in and go to ISSUE.
REQ-009 SHALL drive fu_req_valid = captured fu_sel in ISSUE, zero otherwise; on selected fu_req_ready go to WAIT, or to DONE if the selected fu_rsp_valid is also high that cycle.
REQ-010 SHALL, in WAIT, on selected fu_rsp_valid, latch fu_rsp_data slice and go to DONE; unselected fu_rsp_valid SHALL be ignored.
REQ-011 SHALL assert valid_out only in DONE; payload SHALL hold stable until ready_out.
REQ-012 SHALL raise flush_req for exactly one cycle, the cycle of entering DONE, when fu_bj_taken != captured pred_taken; flush_pc = fu_bj_pc if taken, else pc+4 (mod 2^PC_W).
REQ-013 SHALL, on i_kill: ISSUE->IDLE; WAIT->DRAIN; DONE->IDLE; IDLE unaffected; no flush_req and no valid_out for a killed op.
REQ-014 SHALL, in DRAIN, discard the selected response and go to IDLE on its fu_rsp_valid; ready_in SHALL stay low in DRAIN.
REQ-015 SHALL give i_kill priority over a simultaneous accept, response or ready_out.
REQ-016 SHALL compute fwd_pending = rd_wen & rd_idx!=0 & state in {ISSUE, WAIT}.
REQ-017 SHALL compute fwd_valid = rd_wen & rd_idx!=0 & state==DONE; fwd_rd_idx=o_rd_idx, fwd_data=o_wb_data.
REQ-018 SHALL treat zero or multi-hot i_fu_sel as no-FU: skip ISSUE/WAIT, enter DONE with wb_data 0, rd_wen 0.

Reset
REQ-019 SHALL reset to IDLE with ready_in=1 and valid_out, fu_req_valid, flush_req, fwd_pending, fwd_valid, o_rd_wen = 0, all data outputs 0.
REQ-020 SHALL abandon any in-flight op on reset mid-operation; late fu_rsp_valid after reset SHALL be ignored in IDLE.

Configuration
REQ-021 SHALL, with CORE_EX_FWD_EN defined, implement REQ-016/REQ-017; without it, fwd_pending, fwd_valid, fwd_rd_idx, fwd_data SHALL be tied 0 and ports retained.

Structure
REQ-022 SHALL place state encoding and FU index constants (ALU=0, LSU=1, MDU=2) in shared package core_ex_pkg.
REQ-023 SHALL use one sub-module core_ex_rsp_mux (one-hot select of N_FU response slices).

Verification
REQ-024 ALU op, fu_sel=001, req_ready and rsp same cycle, rd=5, data 0x1234 -> valid_out 2 cycles after accept, o_wb_data 0x1234, fwd_valid high.
REQ-025 MDU op, fu_sel=100, rsp 10 cycles after issue -> fwd_pending high for 10 cycles, ready_in low, then DONE with data.
REQ-026 Branch pred_taken=0, bj_taken=1, bj_pc 0x80000040 -> single-cycle flush_req, flush_pc 0x80000040; pred=1, bj_taken=0, pc 0x80000010 -> flush_pc 0x80000014.
REQ-027 i_kill in WAIT on LSU op -> DRAIN, response dropped, no valid_out, no flush_req, ready_in returns next cycle after response.
REQ-028 ready_out low 4 cycles in DONE -> payload stable; ready_out with valid_in -> back-to-back accept, no bubble.
REQ-029 rst_n low during WAIT -> all outputs reset values immediately; rd=0 op -> fwd_pending/fwd_valid never asserted.

Source files
------------

// File: rtl/core_ex_pkg.sv
// Shared EX-stage types: controller state encoding and FU slot indices.
package core_ex_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } ex_state_e;

    localparam int FU_ALU = 0;
    localparam int FU_LSU = 1;
    localparam int FU_MDU = 2;

endpackage

// File: rtl/core_ex_rsp_mux.sv
// One-hot select of the per-FU response strobes and data slices.
module core_ex_rsp_mux #(
    parameter int XLEN = 32,
    parameter int N_FU = 3
) (
    input  logic [N_FU-1:0]      sel_i,
    input  logic [N_FU-1:0]      rsp_valid_i,
    input  logic [N_FU*XLEN-1:0] rsp_data_i,
    output logic                 valid_o,
    output logic [XLEN-1:0]      data_o
);

    assign valid_o = |(sel_i & rsp_valid_i);

    always_comb begin
        data_o = '0;
        for (int k = 0; k < N_FU; k++) begin
            if (sel_i[k]) data_o = data_o | rsp_data_i[k*XLEN +: XLEN];
        end
    end

endmodule

// File: rtl/core_ex_pipe_ctrl.sv
// EX-stage controller: issue to one FU, collect result, writeback, redirect.
// Define CORE_EX_FWD_EN to drive the forwarding outputs; otherwise tied 0.
module core_ex_pipe_ctrl
    import core_ex_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int PC_W    = 32,
    parameter int RFIDX_W = 5,
    parameter int N_FU    = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid_in,
    output logic                 ready_in,
    input  logic [PC_W-1:0]      i_pc,
    input  logic                 i_rd_wen,
    input  logic [RFIDX_W-1:0]   i_rd_idx,
    input  logic [N_FU-1:0]      i_fu_sel,
    input  logic                 i_pred_taken,
    output logic [N_FU-1:0]      fu_req_valid,
    input  logic [N_FU-1:0]      fu_req_ready,
    input  logic [N_FU-1:0]      fu_rsp_valid,
    input  logic [N_FU*XLEN-1:0] fu_rsp_data,
    input  logic                 fu_bj_taken,
    input  logic [PC_W-1:0]      fu_bj_pc,
    input  logic                 i_kill,
    output logic                 valid_out,
    input  logic                 ready_out,
    output logic                 o_rd_wen,
    output logic [RFIDX_W-1:0]   o_rd_idx,
    output logic [XLEN-1:0]      o_wb_data,
    output logic                 flush_req,
    output logic [PC_W-1:0]      flush_pc,
    output logic                 fwd_pending,
    output logic                 fwd_valid,
    output logic [RFIDX_W-1:0]   fwd_rd_idx,
    output logic [XLEN-1:0]      fwd_data
);

    ex_state_e state_q, state_d;

    logic [PC_W-1:0]    pc_q;
    logic               rd_wen_q;
    logic [RFIDX_W-1:0] rd_idx_q;
    logic [N_FU-1:0]    fu_sel_q;
    logic               pred_q;
    logic [XLEN-1:0]    wb_q;
    logic               flush_q;
    logic [PC_W-1:0]    flush_pc_q;

    logic            accept;
    logic            in_onehot;
    logic            req_fire;
    logic            rsp_hit;
    logic            rsp_take;
    logic [XLEN-1:0] rsp_data;

    core_ex_rsp_mux #(
        .XLEN (XLEN),
        .N_FU (N_FU)
    ) u_rsp_mux (
        .sel_i       (fu_sel_q),
        .rsp_valid_i (fu_rsp_valid),
        .rsp_data_i  (fu_rsp_data),
        .valid_o     (rsp_hit),
        .data_o      (rsp_data)
    );

    assign accept    = valid_in & ready_in;
    assign in_onehot = (i_fu_sel != '0) &&
                       ((i_fu_sel & (i_fu_sel - N_FU'(1))) == '0);
    assign req_fire  = |(fu_sel_q & fu_req_ready);
    assign rsp_take  = ~i_kill & rsp_hit &
                       (((state_q == S_ISSUE) & req_fire) | (state_q == S_WAIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) state_d = in_onehot ? S_ISSUE : S_DONE;
            end
            S_ISSUE: begin
                if (i_kill)        state_d = S_IDLE;
                else if (req_fire) state_d = rsp_hit ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
                // A kill coinciding with the response has nothing left to drain
                if (i_kill)       state_d = rsp_hit ? S_IDLE : S_DRAIN;
                else if (rsp_hit) state_d = S_DONE;
            end
            S_DONE: begin
                if (i_kill)         state_d = S_IDLE;
                else if (accept)    state_d = in_onehot ? S_ISSUE : S_DONE;
                else if (ready_out) state_d = S_IDLE;
            end
            S_DRAIN: begin
                if (rsp_hit) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ready_in     = (state_q == S_IDLE) |
                       ((state_q == S_DONE) & ready_out & ~i_kill);
        valid_out    = (state_q == S_DONE) & ~i_kill;
        fu_req_valid = (state_q == S_ISSUE) ? fu_sel_q : '0;
        flush_req    = flush_q & (state_q == S_DONE) & ~i_kill;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= '0;
            rd_wen_q   <= 1'b0;
            rd_idx_q   <= '0;
            fu_sel_q   <= '0;
            pred_q     <= 1'b0;
            wb_q       <= '0;
            flush_q    <= 1'b0;
            flush_pc_q <= '0;
        end else begin
            flush_q <= 1'b0;
            if (accept) begin
                pc_q     <= i_pc;
                rd_wen_q <= i_rd_wen & in_onehot;
                rd_idx_q <= i_rd_idx;
                fu_sel_q <= i_fu_sel;
                pred_q   <= i_pred_taken;
                wb_q     <= '0;
            end
            if (rsp_take) begin
                wb_q       <= rsp_data;
                flush_q    <= fu_bj_taken != pred_q;
                flush_pc_q <= fu_bj_taken ? fu_bj_pc : pc_q + PC_W'(4);
            end
        end
    end

    assign o_rd_wen  = rd_wen_q;
    assign o_rd_idx  = rd_idx_q;
    assign o_wb_data = wb_q;
    assign flush_pc  = flush_pc_q;

`ifdef CORE_EX_FWD_EN
    logic rd_live;
    assign rd_live     = rd_wen_q & (rd_idx_q != '0);
    assign fwd_pending = rd_live & ((state_q == S_ISSUE) | (state_q == S_WAIT));
    assign fwd_valid   = rd_live & (state_q == S_DONE);
    assign fwd_rd_idx  = rd_idx_q;
    assign fwd_data    = wb_q;
`else
    assign fwd_pending = 1'b0;
    assign fwd_valid   = 1'b0;
    assign fwd_rd_idx  = '0;
    assign fwd_data    = '0;
`endif

endmodule

// File: tb/tb_core_ex_pipe_ctrl.sv
// Directed bench for core_ex_pipe_ctrl with hand-computed expectations.
module tb_core_ex_pipe_ctrl;

    localparam int XLEN = 32;
    localparam int PC_W = 32;
    localparam int RW   = 5;
    localparam int NF   = 3;

`ifdef CORE_EX_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            valid_in, ready_in;
    logic [PC_W-1:0] i_pc;
    logic            i_rd_wen;
    logic [RW-1:0]   i_rd_idx;
    logic [NF-1:0]   i_fu_sel;
    logic            i_pred_taken;
    logic [NF-1:0]   fu_req_valid, fu_req_ready, fu_rsp_valid;
    logic [NF*XLEN-1:0] fu_rsp_data;
    logic            fu_bj_taken;
    logic [PC_W-1:0] fu_bj_pc;
    logic            i_kill;
    logic            valid_out, ready_out;
    logic            o_rd_wen;
    logic [RW-1:0]   o_rd_idx;
    logic [XLEN-1:0] o_wb_data;
    logic            flush_req;
    logic [PC_W-1:0] flush_pc;
    logic            fwd_pending, fwd_valid;
    logic [RW-1:0]   fwd_rd_idx;
    logic [XLEN-1:0] fwd_data;

    int checks = 0;
    int failures = 0;
    int pend_cnt;
    int bad_rdy;

    core_ex_pipe_ctrl #(
        .XLEN(XLEN), .PC_W(PC_W), .RFIDX_W(RW), .N_FU(NF)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .valid_in(valid_in), .ready_in(ready_in),
        .i_pc(i_pc), .i_rd_wen(i_rd_wen), .i_rd_idx(i_rd_idx),
        .i_fu_sel(i_fu_sel), .i_pred_taken(i_pred_taken),
        .fu_req_valid(fu_req_valid), .fu_req_ready(fu_req_ready),
        .fu_rsp_valid(fu_rsp_valid), .fu_rsp_data(fu_rsp_data),
        .fu_bj_taken(fu_bj_taken), .fu_bj_pc(fu_bj_pc),
        .i_kill(i_kill),
        .valid_out(valid_out), .ready_out(ready_out),
        .o_rd_wen(o_rd_wen), .o_rd_idx(o_rd_idx), .o_wb_data(o_wb_data),
        .flush_req(flush_req), .flush_pc(flush_pc),
        .fwd_pending(fwd_pending), .fwd_valid(fwd_valid),
        .fwd_rd_idx(fwd_rd_idx), .fwd_data(fwd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        valid_in     = 1'b0;
        i_pc         = '0;
        i_rd_wen     = 1'b0;
        i_rd_idx     = '0;
        i_fu_sel     = '0;
        i_pred_taken = 1'b0;
        fu_req_ready = '0;
        fu_rsp_valid = '0;
        fu_rsp_data  = '0;
        fu_bj_taken  = 1'b0;
        fu_bj_pc     = '0;
        i_kill       = 1'b0;
        ready_out    = 1'b1;
    endtask

    task automatic op(input logic [PC_W-1:0] pc, input logic [RW-1:0] rd,
                      input logic [NF-1:0] sel, input logic pred);
        valid_in     = 1'b1;
        i_pc         = pc;
        i_rd_wen     = 1'b1;
        i_rd_idx     = rd;
        i_fu_sel     = sel;
        i_pred_taken = pred;
    endtask

    initial begin
        idle_in();
        rst_n = 1'b0;
        #1;
        check("rst_ready_in", ready_in, 1);
        check("rst_valid_out", valid_out, 0);
        check("rst_fu_req", fu_req_valid, 0);
        check("rst_flush", flush_req, 0);
        check("rst_rd_wen", o_rd_wen, 0);
        check("rst_wb_data", o_wb_data, 0);
        check("rst_fwd", {fwd_pending, fwd_valid, fwd_rd_idx, fwd_data}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        // ALU, request and response in the same cycle
        op(32'h100, 5'd5, 3'b001, 1'b0);
        cyc();
        valid_in = 1'b0;
        fu_req_ready = 3'b001;
        fu_rsp_valid = 3'b001;
        fu_rsp_data[0 +: XLEN] = 32'h1234;
        #1;
        check("alu_req", fu_req_valid, 3'b001);
        check("alu_vout_issue", valid_out, 0);
        check("alu_pend", fwd_pending, FWD);
        cyc();
        idle_in();
        check("alu_vout", valid_out, 1);
        check("alu_data", o_wb_data, 32'h1234);
        check("alu_rd", {o_rd_wen, o_rd_idx}, {1'b1, 5'd5});
        check("alu_fwd_valid", fwd_valid, FWD);
        check("alu_fwd_data", fwd_data, FWD ? 32'h1234 : 0);
        check("alu_noflush", flush_req, 0);
        cyc();
        check("alu_idle", {ready_in, valid_out}, 2'b10);

        // MDU, long latency, unselected response ignored, stalled writeback
        op(32'h200, 5'd7, 3'b100, 1'b0);
        cyc();
        valid_in = 1'b0;
        fu_req_ready = 3'b100;
        ready_out = 1'b0;
        pend_cnt = 0;
        bad_rdy = 0;
        #1;
        pend_cnt += int'(fwd_pending);
        bad_rdy += int'(ready_in);
        cyc();
        fu_req_ready = '0;
        for (int i = 0; i < 9; i++) begin
            fu_rsp_valid = '0;
            fu_rsp_data = '0;
            if (i == 2) begin
                fu_rsp_valid = 3'b001;
                fu_rsp_data[0 +: XLEN] = 32'hDEAD;
            end
            if (i == 8) begin
                fu_rsp_valid = 3'b100;
                fu_rsp_data[2*XLEN +: XLEN] = 32'hCAFE;
            end
            #1;
            pend_cnt += int'(fwd_pending);
            bad_rdy += int'(ready_in);
            if (i < 8) check("mdu_wait_vout", valid_out, 0);
            cyc();
        end
        fu_rsp_valid = '0;
        fu_rsp_data = '0;
        check("mdu_pend_cycles", pend_cnt, FWD ? 10 : 0);
        check("mdu_ready_low", bad_rdy, 0);
        for (int i = 0; i < 4; i++) begin
            check("hold_vout", valid_out, 1);
            check("hold_data", o_wb_data, 32'hCAFE);
            check("hold_ready_in", ready_in, 0);
            cyc();
        end
        ready_out = 1'b1;
        op(32'h300, 5'd3, 3'b011, 1'b0);
        #1;
        check("b2b_ready_in", ready_in, 1);
        cyc();
        valid_in = 1'b0;
        check("nofu_vout", valid_out, 1);
        check("nofu_data", o_wb_data, 0);
        check("nofu_rd", {o_rd_wen, o_rd_idx}, {1'b0, 5'd3});
        check("nofu_req", fu_req_valid, 0);
        cyc();
        check("nofu_idle", valid_out, 0);

        // Mispredict: predicted not-taken, resolved taken
        op(32'h8000_0000, 5'd1, 3'b001, 1'b0);
        cyc();
        valid_in = 1'b0;
        fu_req_ready = 3'b001;
        fu_rsp_valid = 3'b001;
        fu_bj_taken = 1'b1;
        fu_bj_pc = 32'h8000_0040;
        ready_out = 1'b0;
        cyc();
        fu_req_ready = '0;
        fu_rsp_valid = '0;
        fu_bj_taken = 1'b0;
        check("bj1_flush", flush_req, 1);
        check("bj1_pc", flush_pc, 32'h8000_0040);
        cyc();
        check("bj1_pulse", flush_req, 0);
        check("bj1_vout", valid_out, 1);
        ready_out = 1'b1;
        cyc();

        // Mispredict via WAIT: predicted taken, resolved not-taken
        op(32'h8000_0010, 5'd2, 3'b010, 1'b1);
        cyc();
        valid_in = 1'b0;
        fu_req_ready = 3'b010;
        cyc();
        fu_req_ready = '0;
        fu_rsp_valid = 3'b010;
        fu_bj_pc = 32'h1234_5678;
        cyc();
        fu_rsp_valid = '0;
        check("bj0_flush", flush_req, 1);
        check("bj0_pc", flush_pc, 32'h8000_0014);
        cyc();

        // Kill in WAIT drains the LSU response
        op(32'h400, 5'd4, 3'b010, 1'b0);
        cyc();
        valid_in = 1'b0;
        fu_req_ready = 3'b010;
        cyc();
        fu_req_ready = '0;
        i_kill = 1'b1;
        cyc();
        i_kill = 1'b0;
        check("drain_ready_in", ready_in, 0);
        check("drain_pend", fwd_pending, 0);
        cyc();
        fu_rsp_valid = 3'b010;
        fu_bj_taken = 1'b1;
        #1;
        check("drain_vout", valid_out, 0);
        cyc();
        fu_rsp_valid = '0;
        fu_bj_taken = 1'b0;
        check("drain_back", ready_in, 1);
        check("drain_noflush", {valid_out, flush_req}, 0);

        // rd=0 never forwards
        op(32'h500, 5'd0, 3'b001, 1'b0);
        cyc();
        valid_in = 1'b0;
        fu_req_ready = 3'b001;
        fu_rsp_valid = 3'b001;
        fu_rsp_data[0 +: XLEN] = 32'h55;
        #1;
        check("x0_pend", fwd_pending, 0);
        cyc();
        idle_in();
        check("x0_vout", valid_out, 1);
        check("x0_fwd_valid", fwd_valid, 0);
        cyc();

        // Reset asserted in WAIT; late response ignored
        op(32'h600, 5'd9, 3'b100, 1'b0);
        cyc();
        valid_in = 1'b0;
        fu_req_ready = 3'b100;
        cyc();
        fu_req_ready = '0;
        rst_n = 1'b0;
        #1;
        check("midrst_ready_in", ready_in, 1);
        check("midrst_outs", {valid_out, fu_req_valid, flush_req, fwd_pending}, 0);
        check("midrst_rd", {o_rd_wen, o_rd_idx}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        fu_rsp_valid = 3'b100;
        fu_rsp_data[2*XLEN +: XLEN] = 32'hBEEF;
        cyc();
        fu_rsp_valid = '0;
        check("late_rsp_vout", valid_out, 0);
        check("late_rsp_data", o_wb_data, 0);
        check("late_rsp_ready", ready_in, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
